// File: rtl/mem_port_ctrl.sv
// Single-port memory controller: data accesses win the port, instruction
// fetch fills idle cycles into a 2-entry prefetch queue.
module mem_port_ctrl #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_load,
    input  logic [7:0]  pc_target,
    input  logic        ir_ready,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        MW,
    output logic [7:0]  address,
    output logic [7:0]  DataIn,
    input  logic [15:0] DataOut
);

    localparam logic [1:0] QFULL = 2'(QDEPTH);

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dstate_t;

    dstate_t     dstate_r;
    dstate_t     dstate_s;
    logic        d_grant_s;
    logic        f_grant_s;
    logic        pop_s;
    logic [7:0]  fetch_pc_r;
    logic [1:0]  count_r;
    logic [15:0] q_word_r [2];
    logic [7:0]  q_pc_r   [2];
    logic [15:0] d_rdata_r;

    // Data FSM next state; a request is only granted from D_IDLE so a held
    // request cannot be serviced twice.
    always_comb begin
        dstate_s  = dstate_r;
        d_grant_s = 1'b0;
        case (dstate_r)
            D_IDLE: begin
                if (d_req && !reset) begin
                    d_grant_s = 1'b1;
                    dstate_s  = D_ACK;
                end else begin
                    dstate_s  = D_IDLE;
                end
            end
            D_ACK:   dstate_s = D_IDLE;
            default: dstate_s = D_IDLE;
        endcase
    end

    // Port arbitration and memory-side drive (combinational, no added latency).
    always_comb begin
        f_grant_s = 1'b0;
        pop_s     = 1'b0;
        MW        = 1'b0;
        address   = fetch_pc_r;
        DataIn    = 8'h00;
        if (!reset && !d_grant_s && !pc_load && (count_r < QFULL)) begin
            f_grant_s = 1'b1;
        end else begin
            f_grant_s = 1'b0;
        end
        if ((count_r != 2'd0) && ir_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (d_grant_s) begin
            address = d_addr;
            if (d_we) begin
                MW     = 1'b1;
                DataIn = d_wdata;
            end else begin
                MW     = 1'b0;
                DataIn = 8'h00;
            end
        end else begin
            address = fetch_pc_r;
        end
    end

    // Data FSM state and load-data capture; stores return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            dstate_r  <= D_IDLE;
            d_rdata_r <= 16'h0000;
        end else begin
            dstate_r <= dstate_s;
            if (d_grant_s) begin
                d_rdata_r <= d_we ? 16'h0000 : DataOut;
            end
        end
    end

    // Fetch address: redirect wins, otherwise advance on each fetch grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r <= 8'h00;
        end else if (pc_load) begin
            fetch_pc_r <= pc_target;
        end else if (f_grant_s) begin
            fetch_pc_r <= fetch_pc_r + 8'd1;
        end
    end

    // Prefetch queue kept as a shift pair: entry 0 is always the head.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= 2'd0;
            q_word_r[0] <= 16'h0000;
            q_word_r[1] <= 16'h0000;
            q_pc_r[0]   <= 8'h00;
            q_pc_r[1]   <= 8'h00;
        end else if (pc_load) begin
            count_r <= 2'd0;
        end else begin
            case (count_r)
                2'd0: begin
                    if (f_grant_s) begin
                        q_word_r[0] <= DataOut;
                        q_pc_r[0]   <= fetch_pc_r;
                        count_r     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (f_grant_s && pop_s) begin
                        q_word_r[0] <= DataOut;
                        q_pc_r[0]   <= fetch_pc_r;
                    end else if (f_grant_s) begin
                        q_word_r[1] <= DataOut;
                        q_pc_r[1]   <= fetch_pc_r;
                        count_r     <= 2'd2;
                    end else if (pop_s) begin
                        count_r     <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        q_word_r[0] <= q_word_r[1];
                        q_pc_r[0]   <= q_pc_r[1];
                        count_r     <= 2'd1;
                    end
                end
                default: count_r <= 2'd0;
            endcase
        end
    end

    assign ir_valid = (count_r != 2'd0);
    assign ir       = q_word_r[0];
    assign ir_pc    = q_pc_r[0];
    assign d_ack    = (dstate_r == D_ACK);
    assign d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomized bench for mem_port_ctrl against a queue-based reference model,
// with a 256 x 16 combinational memory attached to the port.
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        reset, pc_load, ir_ready, d_req, d_we;
    logic [7:0]  pc_target, d_addr, d_wdata;
    logic        ir_valid, d_ack, MW;
    logic [15:0] ir, d_rdata, DataOut;
    logic [7:0]  ir_pc, address, DataIn;
    logic        preload;
    logic [15:0] mem [256];

    always #5 clk = ~clk;

    mem_port_ctrl #(.QDEPTH(2)) dut (
        .clk(clk), .reset(reset), .pc_load(pc_load), .pc_target(pc_target),
        .ir_ready(ir_ready), .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .MW(MW), .address(address),
        .DataIn(DataIn), .DataOut(DataOut)
    );

    // Memory attached to the controller's port
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 256; k++) mem[k] <= 16'(k + 256);
        end else if (MW) begin
            mem[address] <= {8'h00, DataIn};
        end
    end
    assign DataOut = mem[address];

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] w;
    } ent_t;

    ent_t        mq[$];
    int          m_fpc;
    bit          m_dack;
    logic [15:0] m_rdata;
    logic [15:0] mm [256];
    int          checks = 0;
    int          errors = 0;
    int          mw_seen = 0;
    bit          last_ack = 1'b0;
    int          acks;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic step();
        bit   dg, fg, pop;
        ent_t e;
        @(negedge clk);
        dg = !reset && !m_dack && d_req;
        fg = !reset && !dg && !pc_load && (mq.size() < 2);
        chk("d_ack", 32'(d_ack), 32'(m_dack));
        if (m_dack) chk("d_rdata", 32'(d_rdata), 32'(m_rdata));
        chk("ir_valid", 32'(ir_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("ir", 32'(ir), 32'(mq[0].w));
            chk("ir_pc", 32'(ir_pc), 32'(mq[0].pc));
        end
        chk("MW", 32'(MW), 32'(dg && d_we));
        chk("address", 32'(address), dg ? 32'(d_addr) : 32'(m_fpc));
        chk("DataIn", 32'(DataIn), (dg && d_we) ? 32'(d_wdata) : 32'h0);
        if (MW) mw_seen++;
        last_ack = m_dack;
        e = '0;
        if (reset) begin
            mq.delete();
            m_fpc   = 0;
            m_dack  = 1'b0;
            m_rdata = 16'h0000;
        end else begin
            pop = (mq.size() != 0) && ir_ready;
            if (pc_load) begin
                mq.delete();
                m_fpc = int'(pc_target);
            end else begin
                if (fg) begin
                    e.pc = 8'(m_fpc);
                    e.w  = mm[m_fpc];
                end
                if (pop) void'(mq.pop_front());
                if (fg) begin
                    mq.push_back(e);
                    m_fpc = (m_fpc + 1) % 256;
                end
            end
            if (dg) begin
                m_rdata = d_we ? 16'h0000 : mm[d_addr];
                if (d_we) mm[d_addr] = {8'h00, d_wdata};
            end
            m_dack = dg;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; preload = 1'b1; pc_load = 1'b0; pc_target = 8'h00;
        ir_ready = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        reset   = 1'b0;
        for (int k = 0; k < 256; k++) mm[k] = 16'(k + 256);
        mq.delete(); m_fpc = 0; m_dack = 1'b0; m_rdata = 16'h0000;

        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ir_pc", 32'(ir_pc), 32'h0);
        chk("rst_d_ack", 32'(d_ack), 32'h0);
        chk("rst_d_rdata", 32'(d_rdata), 32'h0);
        chk("rst_MW", 32'(MW), 32'h0);

        // Fill with decode stalled: two fetches, then the port holds at 2
        repeat (5) step();
        chk("fill_valid", 32'(ir_valid), 32'h1);
        chk("fill_ir", 32'(ir), 32'h0100);
        chk("fill_ir_pc", 32'(ir_pc), 32'h0);
        chk("fill_hold_addr", 32'(address), 32'h2);

        // Streaming through the 255 -> 0 wrap
        ir_ready = 1'b1;
        repeat (300) step();

        // Store 0xAB to 0x40, then load it back
        mw_seen = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'hAB;
        step();
        chk("st_ack", 32'(d_ack), 32'h1);
        step();
        d_we = 1'b0; d_wdata = 8'h00;
        step();
        chk("ld_ack", 32'(d_ack), 32'h1);
        chk("ld_rdata", 32'(d_rdata), 32'h00AB);
        d_req = 1'b0;
        step();
        chk("mw_once", 32'(mw_seen), 32'h1);

        // Continuously held request with alternating load addresses
        acks = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_ack) begin
                acks++;
                d_addr = 8'($urandom_range(0, 255));
            end
        end
        chk("held_acks", 32'(acks), 32'd10);
        d_req = 1'b0;
        step();

        // Redirect while full and popping
        ir_ready = 1'b0;
        repeat (3) step();
        chk("pre_flush_full", 32'(ir_valid), 32'h1);
        ir_ready = 1'b1; pc_load = 1'b1; pc_target = 8'h80;
        step();
        pc_load = 1'b0;
        chk("flush_empty", 32'(ir_valid), 32'h0);
        step();
        chk("redir_valid", 32'(ir_valid), 32'h1);
        chk("redir_pc", 32'(ir_pc), 32'h80);

        // Reset landing in a D_ACK cycle
        ir_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h05;
        step();
        d_req = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_ack_cancel", 32'(d_ack), 32'h0);
        chk("rst2_valid", 32'(ir_valid), 32'h0);
        chk("rst2_rdata", 32'(d_rdata), 32'h0);
        chk("rst2_addr", 32'(address), 32'h0);
        repeat (2) step();
        chk("restart_pc", 32'(ir_pc), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ir_ready  = ($urandom_range(0, 3) != 0);
            pc_load   = ($urandom_range(0, 39) == 0);
            pc_target = 8'($urandom_range(0, 255));
            reset     = ($urandom_range(0, 499) == 0);
            if (!d_req || last_ack) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 8'($urandom_range(0, 255));
                d_wdata = 8'($urandom_range(0, 255));
            end
            step();
        end
        reset = 1'b0; pc_load = 1'b0; d_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
